// File: rtl/timer_alarm_if.sv
// Bus slave interface for the compare/alarm stage: register strobes, data and interrupt.
// Latency: none in the interface itself; rdata and irq are registered inside the slave.
// Backpressure: none, since every strobe is accepted on the cycle it is presented.
interface timer_alarm_if #(
   parameter int WIDTH = 16
);
   logic             wr_en;
   logic             rd_en;
   logic [1:0]       addr;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH-1:0] rdata;
   logic             irq;

   // processor side
   modport master (output wr_en, rd_en, addr, wdata, input rdata, irq);
   // timer side
   modport slave  (input wr_en, rd_en, addr, wdata, output rdata, irq);
endinterface

// File: rtl/timer_alarm.sv
// Compare/alarm stage: counts ticks since arming and raises irq when COMPARE is reached.
// Latency: fire lands on the tick edge, irq follows 1 clk later, rdata is valid 1 clk after rd_en.
// Backpressure: none; the bus strobes are single-cycle and always accepted.
module timer_alarm #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] timer_count,
   timer_alarm_if.slave     bus
);

   localparam logic [1:0] ADDR_CTRL    = 2'd0;
   localparam logic [1:0] ADDR_COMPARE = 2'd1;
   localparam logic [1:0] ADDR_STATUS  = 2'd2;
   localparam logic [1:0] ADDR_CAPTURE = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       ctrl_q, ctrl_d;          // [0] enable, [1] periodic, [2] irq_en
   logic [WIDTH-1:0] compare_q, compare_d;
   logic             pending_q, pending_d;
   logic             overrun_q, overrun_d;
   logic [WIDTH-1:0] capture_q, capture_d;
   logic [WIDTH:0]   elapsed_q, elapsed_d;    // one spare bit so sum never wraps before the compare
   logic [WIDTH-1:0] count_prev_q, count_prev_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic             irq_q, irq_d;

   logic [WIDTH-1:0] delta;
   logic [WIDTH:0]   sum;
   logic             fire;
   logic             wr_ctrl, wr_compare, wr_status;

   // Next-state logic: tick accumulation, fire detection, register writes and read mux.
   // Later assignments override earlier ones, which encodes the collision priorities:
   // fire beats a STATUS clear, a CTRL write beats the fire for enable/mode/state.
   always_comb begin
      delta      = timer_count - count_prev_q;   // modulo 2^WIDTH, so a wrap counts as one tick
      sum        = elapsed_q + {1'b0, delta};
      fire       = (state_q == ARMED) && (compare_q != '0) && (sum >= {1'b0, compare_q});
      wr_ctrl    = bus.wr_en && (bus.addr == ADDR_CTRL);
      wr_compare = bus.wr_en && (bus.addr == ADDR_COMPARE);
      wr_status  = bus.wr_en && (bus.addr == ADDR_STATUS);

      state_d      = state_q;
      ctrl_d       = ctrl_q;
      compare_d    = compare_q;
      pending_d    = pending_q;
      overrun_d    = overrun_q;
      capture_d    = capture_q;
      elapsed_d    = '0;
      count_prev_d = timer_count;
      rdata_d      = rdata_q;
      irq_d        = pending_q & ctrl_q[2];

      if (state_q == ARMED) begin
         elapsed_d = sum;
      end

      if (wr_status) begin
         pending_d = pending_q & ~bus.wdata[0];
         overrun_d = overrun_q & ~bus.wdata[1];
      end

      if (fire) begin
         capture_d = timer_count;
         pending_d = 1'b1;
         if (pending_q) begin
            overrun_d = 1'b1;
         end
         if (ctrl_q[1]) begin
            elapsed_d = sum - {1'b0, compare_q};   // keep the remainder so periods do not drift
         end else begin
            ctrl_d[0] = 1'b0;
            elapsed_d = '0;
            state_d   = DONE;
         end
      end

      if (wr_compare) begin
         compare_d = bus.wdata;
      end

      if (wr_ctrl) begin
         ctrl_d    = bus.wdata[2:0];
         elapsed_d = '0;
         state_d   = bus.wdata[0] ? ARMED : IDLE;
      end

      // Reads see the pre-edge register values, so a read on a fire edge returns the old data.
      if (bus.rd_en) begin
         case (bus.addr)
            ADDR_CTRL:    rdata_d = {{(WIDTH-3){1'b0}}, ctrl_q};
            ADDR_COMPARE: rdata_d = compare_q;
            ADDR_STATUS:  rdata_d = {{(WIDTH-2){1'b0}}, overrun_q, pending_q};
            default:      rdata_d = capture_q;
         endcase
      end
   end

   // State registers with asynchronous active-high reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         ctrl_q       <= '0;
         compare_q    <= '0;
         pending_q    <= 1'b0;
         overrun_q    <= 1'b0;
         capture_q    <= '0;
         elapsed_q    <= '0;
         count_prev_q <= '0;
         rdata_q      <= '0;
         irq_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         ctrl_q       <= ctrl_d;
         compare_q    <= compare_d;
         pending_q    <= pending_d;
         overrun_q    <= overrun_d;
         capture_q    <= capture_d;
         elapsed_q    <= elapsed_d;
         count_prev_q <= count_prev_d;
         rdata_q      <= rdata_d;
         irq_q        <= irq_d;
      end
   end

   assign bus.rdata = rdata_q;
   assign bus.irq   = irq_q;

endmodule

// File: tb/tb_timer_alarm.sv
// Directed bench for timer_alarm: reset, one-shot, periodic, wrap, jump, collision/disable.
// Latency: inputs change on the falling edge, outputs are sampled on the falling edge.
// Backpressure: none; bus strobes are held for exactly one rising edge.
module tb_timer_alarm;

   localparam logic [1:0] A_CTRL = 2'd0;
   localparam logic [1:0] A_CMP  = 2'd1;
   localparam logic [1:0] A_STAT = 2'd2;
   localparam logic [1:0] A_CAP  = 2'd3;

   logic        clk;
   logic        rst;
   logic [15:0] timer_count;
   int          tests;
   int          failed;
   logic [15:0] rd;

   timer_alarm_if #(.WIDTH(16)) bus ();

   timer_alarm #(.WIDTH(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .timer_count (timer_count),
      .bus         (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic bus_wr(input logic [1:0] a, input logic [15:0] d);
      @(negedge clk);
      bus.wr_en = 1'b1; bus.addr = a; bus.wdata = d;
      @(negedge clk);
      bus.wr_en = 1'b0;
   endtask

   task automatic bus_rd(input logic [1:0] a, output logic [15:0] d);
      @(negedge clk);
      bus.rd_en = 1'b1; bus.addr = a;
      @(negedge clk);
      bus.rd_en = 1'b0;
      d = bus.rdata;
   endtask

   // Present a new count and hold it for four clocks.
   task automatic step(input logic [15:0] v);
      @(negedge clk);
      timer_count = v;
      repeat (3) @(negedge clk);
   endtask

   // Disable, park the count, clear STATUS, then program COMPARE and CTRL.
   task automatic setup(input logic [15:0] cnt, input logic [15:0] cmp, input logic [15:0] ctl);
      bus_wr(A_CTRL, 16'h0000);
      step(cnt);
      bus_wr(A_STAT, 16'h0003);
      bus_wr(A_CMP, cmp);
      bus_wr(A_CTRL, ctl);
   endtask

   task automatic test_reset();
      rst = 1'b1; timer_count = 16'h0000;
      bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.addr = 2'd0; bus.wdata = 16'h0000;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      tests++; if (bus.irq !== 1'b0) begin failed++; $display("FAIL reset_irq: got %b want 0", bus.irq); end
      tests++; if (bus.rdata !== 16'h0000) begin failed++; $display("FAIL reset_rdata: got %h want 0000", bus.rdata); end
      // Build up live state so the mid-cycle reset has something to clear.
      bus_wr(A_CMP, 16'h0001);
      bus_wr(A_CTRL, 16'h0005);
      step(16'h0001);
      bus_rd(A_CMP, rd);
      tests++; if (rd !== 16'h0001) begin failed++; $display("FAIL pre_reset_cmp: got %h want 0001", rd); end
      tests++; if (bus.irq !== 1'b1) begin failed++; $display("FAIL pre_reset_irq: got %b want 1", bus.irq); end
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      tests++; if (bus.irq !== 1'b0) begin failed++; $display("FAIL async_rst_irq: got %b want 0", bus.irq); end
      tests++; if (bus.rdata !== 16'h0000) begin failed++; $display("FAIL async_rst_rdata: got %h want 0000", bus.rdata); end
      @(negedge clk);
      rst = 1'b0;
      for (int a = 0; a < 4; a++) begin
         bus_rd(2'(a), rd);
         tests++; if (rd !== 16'h0000) begin failed++; $display("FAIL post_reset_reg%0d: got %h want 0000", a, rd); end
      end
      // COMPARE is 0 after reset, so arming must never fire.
      bus_wr(A_CTRL, 16'h0005);
      step(16'h0002); step(16'h0003); step(16'h0004);
      bus_rd(A_STAT, rd);
      tests++; if (rd !== 16'h0000) begin failed++; $display("FAIL cmp0_no_fire: got %h want 0000", rd); end
      tests++; if (bus.irq !== 1'b0) begin failed++; $display("FAIL cmp0_irq: got %b want 0", bus.irq); end
   endtask

   task automatic test_oneshot();
      setup(16'd100, 16'd5, 16'h0005);
      for (int c = 101; c <= 104; c++) step(16'(c));
      tests++; if (bus.irq !== 1'b0) begin failed++; $display("FAIL oneshot_early_irq: got %b want 0", bus.irq); end
      @(negedge clk);
      timer_count = 16'd105;
      @(negedge clk);
      tests++; if (bus.irq !== 1'b0) begin failed++; $display("FAIL oneshot_irq_lat0: got %b want 0", bus.irq); end
      @(negedge clk);
      tests++; if (bus.irq !== 1'b1) begin failed++; $display("FAIL oneshot_irq_lat1: got %b want 1", bus.irq); end
      bus_rd(A_STAT, rd);
      tests++; if (rd !== 16'h0001) begin failed++; $display("FAIL oneshot_status: got %h want 0001", rd); end
      bus_rd(A_CAP, rd);
      tests++; if (rd !== 16'd105) begin failed++; $display("FAIL oneshot_capture: got %h want 0069", rd); end
      bus_rd(A_CTRL, rd);
      tests++; if (rd !== 16'h0004) begin failed++; $display("FAIL oneshot_ctrl: got %h want 0004", rd); end
      // In DONE further ticks must not fire again.
      for (int c = 106; c <= 112; c++) step(16'(c));
      bus_rd(A_CAP, rd);
      tests++; if (rd !== 16'd105) begin failed++; $display("FAIL oneshot_done_capture: got %h want 0069", rd); end
      bus_rd(A_STAT, rd);
      tests++; if (rd !== 16'h0001) begin failed++; $display("FAIL oneshot_done_status: got %h want 0001", rd); end
   endtask

   task automatic test_periodic();
      logic [15:0] exp_cap;
      setup(16'd0, 16'd3, 16'h0007);
      for (int c = 1; c <= 9; c++) begin
         step(16'(c));
         if (c >= 3) begin
            exp_cap = 16'((c / 3) * 3);
            bus_rd(A_CAP, rd);
            tests++; if (rd !== exp_cap) begin failed++; $display("FAIL periodic_capture_at_%0d: got %h want %h", c, rd, exp_cap); end
         end
         if (c == 3 || c == 5) begin
            bus_rd(A_STAT, rd);
            tests++; if (rd !== 16'h0001) begin failed++; $display("FAIL periodic_status_at_%0d: got %h want 0001", c, rd); end
         end
      end
      bus_rd(A_STAT, rd);
      tests++; if (rd !== 16'h0003) begin failed++; $display("FAIL periodic_overrun: got %h want 0003", rd); end
      bus_rd(A_CTRL, rd);
      tests++; if (rd !== 16'h0007) begin failed++; $display("FAIL periodic_ctrl: got %h want 0007", rd); end
   endtask

   task automatic test_wrap();
      setup(16'hFFFE, 16'd3, 16'h0005);
      step(16'hFFFF);
      step(16'h0000);
      bus_rd(A_STAT, rd);
      tests++; if (rd !== 16'h0000) begin failed++; $display("FAIL wrap_early_status: got %h want 0000", rd); end
      step(16'h0001);
      bus_rd(A_CAP, rd);
      tests++; if (rd !== 16'h0001) begin failed++; $display("FAIL wrap_capture: got %h want 0001", rd); end
      bus_rd(A_STAT, rd);
      tests++; if (rd !== 16'h0001) begin failed++; $display("FAIL wrap_status: got %h want 0001", rd); end
   endtask

   task automatic test_jump();
      setup(16'd10, 16'd3, 16'h0007);
      step(16'd14);
      bus_rd(A_CAP, rd);
      tests++; if (rd !== 16'd14) begin failed++; $display("FAIL jump_capture: got %h want 000e", rd); end
      bus_rd(A_STAT, rd);
      tests++; if (rd !== 16'h0001) begin failed++; $display("FAIL jump_single_fire: got %h want 0001", rd); end
      bus_wr(A_STAT, 16'h0003);
      step(16'd15);
      bus_rd(A_STAT, rd);
      tests++; if (rd !== 16'h0000) begin failed++; $display("FAIL jump_remainder_early: got %h want 0000", rd); end
      step(16'd16);
      bus_rd(A_CAP, rd);
      tests++; if (rd !== 16'd16) begin failed++; $display("FAIL jump_second_fire: got %h want 0010", rd); end
   endtask

   task automatic test_collision();
      setup(16'd20, 16'd2, 16'h0007);
      step(16'd21);
      step(16'd22);
      tests++; if (bus.irq !== 1'b1) begin failed++; $display("FAIL coll_first_irq: got %b want 1", bus.irq); end
      step(16'd23);
      // STATUS clear of pending lands on the same edge as the next fire.
      @(negedge clk);
      timer_count = 16'd24;
      bus.wr_en = 1'b1; bus.addr = A_STAT; bus.wdata = 16'h0001;
      @(negedge clk);
      bus.wr_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tests++; if (bus.irq !== 1'b1) begin failed++; $display("FAIL coll_irq_cycle%0d: got %b want 1", k, bus.irq); end
         @(negedge clk);
      end
      bus_rd(A_STAT, rd);
      tests++; if (rd !== 16'h0003) begin failed++; $display("FAIL coll_status: got %h want 0003", rd); end
      bus_rd(A_CAP, rd);
      tests++; if (rd !== 16'd24) begin failed++; $display("FAIL coll_capture: got %h want 0018", rd); end
      // Disable mid-count: one tick in, then ticks that would otherwise fire.
      step(16'd25);
      bus_wr(A_CTRL, 16'h0006);
      for (int c = 26; c <= 30; c++) step(16'(c));
      bus_rd(A_CAP, rd);
      tests++; if (rd !== 16'd24) begin failed++; $display("FAIL disable_capture: got %h want 0018", rd); end
      bus_rd(A_STAT, rd);
      tests++; if (rd !== 16'h0003) begin failed++; $display("FAIL disable_status: got %h want 0003", rd); end
      bus_rd(A_CTRL, rd);
      tests++; if (rd !== 16'h0006) begin failed++; $display("FAIL disable_ctrl: got %h want 0006", rd); end
   endtask

   initial begin
      tests = 0;
      failed = 0;
      test_reset();
      test_oneshot();
      test_periodic();
      test_wrap();
      test_jump();
      test_collision();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
